// File: rtl/c2hdl_bus_responder.sv
// c2hdl_bus_responder: valid/ready bus target with byte-lane SRAM, TX byte FIFO and RX byte port.
module c2hdl_bus_responder #(
  parameter int          MEM_AW    = 10,
  parameter int          WAIT      = 1,
  parameter logic [31:0] PORT_ADDR = 32'h0001_0000,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        err
);
  localparam logic [31:0] STAT_ADDR = PORT_ADDR + 32'd4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [31:0] la, ld, rd_val;
  logic [2:0] ls;
  logic lw;
  logic [31:0] mem [2**MEM_AW];
  logic [7:0] fifo [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp, lvl_raw;
  logic [3:0] be, tx_level;
  logic full, pop, push, rx_rd, is_sram, is_port, is_stat, mis, bad, avail, go;
  assign is_sram  = la[31:MEM_AW+2] == '0;
  assign is_port  = la[31:2] == PORT_ADDR[31:2];
  assign is_stat  = la[31:2] == STAT_ADDR[31:2];
  assign mis      = (ls == 3'd1 && la[0]) || (ls == 3'd2 && la[1:0] != 2'd0);
  assign bad      = ls > 3'd2 || mis || !(is_sram || is_port || is_stat);
  assign push     = !bad && is_port && lw && ls == 3'd0;
  assign rx_rd    = !bad && !lw && ls == 3'd0 && la == PORT_ADDR;
  assign full     = wp[FIFO_AW] != rp[FIFO_AW] && wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0];
  assign tx_valid = wp != rp;
  assign tx_data  = fifo[rp[FIFO_AW-1:0]];
  assign pop      = tx_valid && tx_ready;
  assign lvl_raw  = wp - rp;
  assign tx_level = lvl_raw > 15 ? 4'd15 : 4'(lvl_raw);
  // a store into a full FIFO or a load with no RX byte holds the access in WAIT
  assign avail    = !(push && full) && !(rx_rd && !rx_valid);
  assign go       = state == S_WAIT && cnt == 4'd0 && avail;
  always_comb begin
    be = ls == 3'd0 ? 4'b0001 << la[1:0] : ls == 3'd1 ? (la[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rd_val = (bad || lw) ? 32'd0 :
             is_sram ? mem[la[MEM_AW+1:2]] :
             is_stat ? {24'd0, full, rx_valid, 2'b00, tx_level} :
             rx_rd   ? {4{rx_data}} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (go && push) fifo[wp[FIFO_AW-1:0]] <= ld[{la[1:0], 3'b000} +: 8];
    if (go && lw && !bad && is_sram)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[la[MEM_AW+1:2]][8*b +: 8] <= ld[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      la       <= 32'd0;
      ld       <= 32'd0;
      ls       <= 3'd0;
      lw       <= 1'b0;
      rdata    <= 32'd0;
      ready    <= 1'b0;
      rx_ready <= 1'b0;
      err      <= 1'b0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      ready    <= 1'b0;
      rx_ready <= 1'b0;
      if (pop) rp <= rp + 1'b1;
      if (go && push) wp <= wp + 1'b1;
      unique case (state)
        S_IDLE: if (valid && !ready) begin
          la    <= addr;
          ls    <= size;
          lw    <= write;
          ld    <= wdata;
          cnt   <= 4'(WAIT);
          state <= S_WAIT;
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (avail) begin
            state    <= S_ACK;
            ready    <= 1'b1;
            rx_ready <= rx_rd;
            rdata    <= rd_val;
            err      <= err | bad;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2hdl_bus_responder.sv
// tb_c2hdl_bus_responder: randomized self-checking bench with byte-array SRAM model and queue TX model.
module tb_c2hdl_bus_responder;
  localparam int          WAIT_CYC = 1;
  localparam logic [31:0] PORT     = 32'h0001_0000;
  logic clk = 0, rstb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [2:0] size = 0;
  logic valid = 0, write = 0, tx_ready = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] rdata;
  logic [7:0] tx_data;
  logic ready, tx_valid, rx_ready, err;
  int pass_cnt = 0, total = 0;
  logic [7:0] ref_mem [64];
  logic [7:0] q [$];

  always #5 clk = ~clk;

  c2hdl_bus_responder #(.MEM_AW(10), .WAIT(WAIT_CYC), .PORT_ADDR(PORT), .FIFO_AW(3)) dut (
    .clk(clk), .rstb(rstb), .addr(addr), .size(size), .valid(valid), .write(write),
    .wdata(wdata), .rdata(rdata), .ready(ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err)
  );

  // one bus access; lat = edges after the sampling edge until ready is seen (-1 on timeout)
  task automatic bus(input logic [31:0] a, input logic [2:0] s, input logic w, input logic [31:0] d,
                     output logic [31:0] rd, output int lat, output logic rdy_after);
    addr = a; size = s; write = w; wdata = d; valid = 1; lat = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (ready) lat = n - 1;
    end
    rd = rdata; valid = 0;
    @(posedge clk); #1;
    rdy_after = ready;
  endtask

  task automatic test_reset;
    rstb = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", ready); else pass_cnt++;
    total++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready: got %b exp 0", rx_ready); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL rst_err: got %b exp 0", err); else pass_cnt++;
    total++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b exp 0", tx_valid); else pass_cnt++;
    total++; if (rdata !== 32'd0) $display("FAIL rst_rdata: got %h exp 0", rdata); else pass_cnt++;
    rstb = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_sram_basic;
    logic [31:0] rd; int lat; logic ra;
    bus(32'h40, 3'd2, 1, 32'hDEADBEEF, rd, lat, ra);
    total++; if (lat != WAIT_CYC + 1) $display("FAIL sw_latency: got %0d exp %0d", lat, WAIT_CYC + 1); else pass_cnt++;
    total++; if (ra !== 1'b0) $display("FAIL ready_pulse_width: got %b exp 0", ra); else pass_cnt++;
    bus(32'h40, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (lat != WAIT_CYC + 1) $display("FAIL lw_latency: got %0d exp %0d", lat, WAIT_CYC + 1); else pass_cnt++;
    total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_40: got %h exp deadbeef", rd); else pass_cnt++;
    bus(32'h41, 3'd0, 1, 32'h0000AB00, rd, lat, ra);
    bus(32'h40, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'hDEADABEF) $display("FAIL sb_merge: got %h exp deadabef", rd); else pass_cnt++;
    total++; if (err !== 1'b0) $display("FAIL err_clean: got %b exp 0", err); else pass_cnt++;
  endtask

  task automatic test_random_sram;
    logic [31:0] rd, d, exp; int lat, w, op, lo, hi, bad_lat; logic ra;
    bad_lat = 0;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      bus(32'h100 + 32'(4 * i), 3'd2, 1, d, rd, lat, ra);
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = d[8*b +: 8];
    end
    for (int i = 0; i < 60; i++) begin
      w = int'($urandom_range(0, 15)); op = int'($urandom_range(0, 4)); d = $urandom;
      if (op == 0) begin lo = int'($urandom_range(0, 3)); hi = lo; end
      else if (op == 1) begin lo = 2 * int'($urandom_range(0, 1)); hi = lo + 1; end
      else begin lo = 0; hi = 3; end
      if (op < 3) begin
        bus(32'h100 + 32'(4 * w + lo), 3'(op), 1, d, rd, lat, ra);
        for (int b = lo; b <= hi; b++) ref_mem[4 * w + b] = d[8*b +: 8];
      end else begin
        lo = int'($urandom_range(0, 3));
        bus(32'h100 + 32'(4 * w + lo), 3'd0, 0, d, rd, lat, ra);
        exp = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
        total++; if (rd !== exp) $display("FAIL rand_load w%0d: got %h exp %h", w, rd, exp); else pass_cnt++;
      end
      if (lat != WAIT_CYC + 1) bad_lat++;
    end
    total++; if (bad_lat != 0) $display("FAIL rand_latency: got %0d bad exp 0", bad_lat); else pass_cnt++;
  endtask

  task automatic test_err;
    logic [31:0] rd; int lat; logic ra;
    bus(32'h43, 3'd1, 1, 32'h12345678, rd, lat, ra);
    total++; if (lat != WAIT_CYC + 1) $display("FAIL misalign_ready: got %0d exp %0d", lat, WAIT_CYC + 1); else pass_cnt++;
    total++; if (err !== 1'b1) $display("FAIL misalign_err: got %b exp 1", err); else pass_cnt++;
    bus(32'h40, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'hDEADABEF) $display("FAIL dropped_store: got %h exp deadabef", rd); else pass_cnt++;
    bus(32'h8000_0000, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'd0) $display("FAIL unmapped_rdata: got %h exp 0", rd); else pass_cnt++;
    bus(32'h40, 3'($urandom_range(3, 7)), 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'd0) $display("FAIL bad_size_rdata: got %h exp 0", rd); else pass_cnt++;
    bus(32'h42, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'd0 || err !== 1'b1) $display("FAIL misalign_lw: got %h/%b exp 0/1", rd, err); else pass_cnt++;
  endtask

  task automatic test_tx;
    logic [7:0] msg [9];
    logic [31:0] rd, d, exp;
    int lat, lane, bad_lat, seen, got;
    logic ra;
    msg = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57, 8'h6f, 8'h72};
    tx_ready = 0; bad_lat = 0; q.delete();
    for (int i = 0; i < 8; i++) begin
      lane = int'($urandom_range(0, 3)); d = $urandom; d[8*lane +: 8] = msg[i];
      bus(PORT + 32'(lane), 3'd0, 1, d, rd, lat, ra);
      q.push_back(msg[i]);
      if (lat != WAIT_CYC + 1) bad_lat++;
    end
    total++; if (bad_lat != 0) $display("FAIL tx_latency: got %0d bad exp 0", bad_lat); else pass_cnt++;
    bus(PORT + 32'd4, 3'd2, 0, 32'h0, rd, lat, ra);
    exp = {24'd0, q.size() == 8, rx_valid, 2'b00, 4'(q.size())};
    total++; if (rd !== exp) $display("FAIL status_full: got %h exp %h", rd, exp); else pass_cnt++;
    addr = PORT; size = 3'd0; write = 1; wdata = {24'd0, msg[8]}; valid = 1; seen = 0;
    repeat (6) begin @(posedge clk); #1; if (ready) seen++; end
    total++; if (seen != 0) $display("FAIL tx_stall: got %0d ready exp 0", seen); else pass_cnt++;
    total++; if (tx_valid !== 1'b1 || tx_data !== q[0]) $display("FAIL tx_head: got %b/%h exp 1/%h", tx_valid, tx_data, q[0]); else pass_cnt++;
    tx_ready = 1;
    @(posedge clk); #1;
    tx_ready = 0;
    void'(q.pop_front());
    q.push_back(msg[8]);
    got = 0;
    for (int k = 0; k < 20 && got == 0; k++) begin @(posedge clk); #1; if (ready) got = 1; end
    total++; if (got != 1) $display("FAIL tx_release: got %0d exp 1", got); else pass_cnt++;
    valid = 0;
    @(posedge clk); #1;
    tx_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      exp = {24'd0, q.pop_front()};
      total++; if (tx_valid !== 1'b1 || tx_data !== exp[7:0]) $display("FAIL tx_drain%0d: got %b/%h exp 1/%h", k, tx_valid, tx_data, exp[7:0]); else pass_cnt++;
      @(posedge clk); #1;
    end
    tx_ready = 0;
    total++; if (tx_valid !== 1'b0) $display("FAIL tx_empty: got %b exp 0", tx_valid); else pass_cnt++;
  endtask

  task automatic test_rx;
    logic [31:0] rd; int lat, seen; logic ra; logic [7:0] b;
    rx_valid = 0; addr = PORT; size = 3'd0; write = 0; valid = 1; seen = 0;
    repeat (5) begin @(posedge clk); #1; if (ready || rx_ready) seen++; end
    total++; if (seen != 0) $display("FAIL rx_stall: got %0d exp 0", seen); else pass_cnt++;
    rx_data = 8'h41; rx_valid = 1;
    @(posedge clk); #1;
    total++; if (ready !== 1'b1 || rx_ready !== 1'b1) $display("FAIL rx_ack: got %b/%b exp 1/1", ready, rx_ready); else pass_cnt++;
    total++; if (rdata !== 32'h41414141) $display("FAIL rx_rdata: got %h exp 41414141", rdata); else pass_cnt++;
    valid = 0; rx_valid = 0;
    @(posedge clk); #1;
    total++; if (rx_ready !== 1'b0 || ready !== 1'b0) $display("FAIL rx_single_pulse: got %b/%b exp 0/0", rx_ready, ready); else pass_cnt++;
    b = 8'($urandom); rx_data = b; rx_valid = 1;
    bus(PORT + 32'd4, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h40) $display("FAIL status_rx: got %h exp 00000040", rd); else pass_cnt++;
    bus(PORT, 3'd0, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== {4{b}} || lat != WAIT_CYC + 1) $display("FAIL rx_rand: got %h/%0d exp %h/%0d", rd, lat, {4{b}}, WAIT_CYC + 1); else pass_cnt++;
    rx_valid = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat; logic ra;
    bus(32'h80, 3'd2, 1, 32'h11111111, rd, lat, ra);
    tx_ready = 0;
    bus(PORT, 3'd0, 1, 32'h5A, rd, lat, ra);
    total++; if (tx_valid !== 1'b1) $display("FAIL pre_reset_tx: got %b exp 1", tx_valid); else pass_cnt++;
    addr = 32'h80; size = 3'd2; write = 1; wdata = 32'h22222222; valid = 1;
    @(posedge clk); #1;
    rstb = 0;
    #1;
    total++; if (ready !== 1'b0 || err !== 1'b0 || tx_valid !== 1'b0) $display("FAIL async_reset: got %b/%b/%b exp 0/0/0", ready, err, tx_valid); else pass_cnt++;
    valid = 0;
    @(posedge clk); #1;
    rstb = 1;
    @(posedge clk); #1;
    bus(32'h80, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h11111111) $display("FAIL reset_no_write: got %h exp 11111111", rd); else pass_cnt++;
    bus(32'h80, 3'd2, 1, 32'h33333333, rd, lat, ra);
    total++; if (lat != WAIT_CYC + 1) $display("FAIL post_reset_sw: got %0d exp %0d", lat, WAIT_CYC + 1); else pass_cnt++;
    bus(32'h80, 3'd2, 0, 32'h0, rd, lat, ra);
    total++; if (rd !== 32'h33333333 || lat != WAIT_CYC + 1) $display("FAIL post_reset_lw: got %h/%0d exp 33333333/%0d", rd, lat, WAIT_CYC + 1); else pass_cnt++;
    total++; if (tx_valid !== 1'b0 || err !== 1'b0) $display("FAIL post_reset_state: got %b/%b exp 0/0", tx_valid, err); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_sram_basic;
    test_random_sram;
    test_err;
    test_tx;
    test_rx;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
